settings_cmd_sequencer: RTL

//   Front-end controller for settings_data_handler. Assembles 5-byte settings frames
//   (cmd, data LSB..MSB) from a byte stream into the handler's 5x8 buffer RAM.

---
 rtl/settings_seq_pkg.sv | 38 +++
 rtl/settings_seq_timer.sv | 27 ++
 rtl/settings_cmd_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/settings_seq_pkg.sv
// Shared types and constants for the settings frame sequencer.
package settings_seq_pkg;

  localparam int FRAME_LEN = 5;
  localparam int ADDR_W    = 3;

  localparam logic [7:0] CMD_MAX_ROW  = 8'd1;
  localparam logic [7:0] CMD_MAX_COL  = 8'd2;
  localparam logic [7:0] CMD_DATA_MIN = 8'd3;
  localparam logic [7:0] CMD_DATA_MAX = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_REPORT  = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    STAT_OK          = 2'd0,
    STAT_HDL_ERR     = 2'd1,
    STAT_TIMEOUT     = 2'd2,
    STAT_FRAME_ABORT = 2'd3
  } status_code_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/settings_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero once it gets there.
module settings_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/settings_cmd_sequencer.sv
// Frame collector and start/wait/recover controller for settings_data_handler.
// Optional inter-byte gap abort: define SETTINGS_SEQ_FRAME_TIMEOUT_EN.
module settings_cmd_sequencer
  import settings_seq_pkg::*;
#(
  parameter int WAIT_TIMEOUT     = 64,
  parameter int RECOVER_CYCLES   = 4,
  parameter int FRAME_GAP_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              hdl_start,
  input  logic              hdl_busy,
  input  logic              hdl_done,
  input  logic              hdl_error,
  output logic              hdl_rst_n,
  output logic              status_valid,
  output logic [1:0]        status_code,
  output logic [15:0]       ok_count,
  output logic [15:0]       err_count,
  output seq_state_e        state_dbg
);

  localparam int TIMER_W = $clog2(max3(WAIT_TIMEOUT, RECOVER_CYCLES, FRAME_GAP_CYCLES) + 1);

  // Handshake: a byte transfers on a cycle where rx_valid and rx_ready are both high;
  // rx_ready is registered and never depends combinationally on rx_valid.
  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  status_code_e      code_q, code_d;
  logic              stale_q, stale_d;
  logic              release_q, release_d;
  logic              alive_q;
  logic              rx_ready_q;
  logic [15:0]       ok_q, err_q;

  logic               accept;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;

  assign accept = rx_valid & rx_ready_q;

  settings_seq_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    code_d    = code_q;
    stale_d   = stale_q;
    release_d = release_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: begin
        // A byte already handshaken takes priority over a stale handler error.
        if (accept) begin
          idx_d   = ADDR_W'(1);
          state_d = ST_COLLECT;
`ifdef SETTINGS_SEQ_FRAME_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(FRAME_GAP_CYCLES - 1);
`endif
        end else if (hdl_error && alive_q) begin
          stale_d   = 1'b1;
          release_d = 1'b0;
          state_d   = ST_RECOVER;
          tmr_load  = 1'b1;
          tmr_val   = TIMER_W'(RECOVER_CYCLES - 1);
        end
      end
      ST_COLLECT: begin
        if (accept) begin
`ifdef SETTINGS_SEQ_FRAME_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(FRAME_GAP_CYCLES - 1);
`endif
          if (idx_q == ADDR_W'(FRAME_LEN - 1)) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
`ifdef SETTINGS_SEQ_FRAME_TIMEOUT_EN
        else if (tmr_zero) begin
          idx_d   = '0;
          code_d  = STAT_FRAME_ABORT;
          state_d = ST_REPORT;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      ST_START: begin
        if (!hdl_busy) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(WAIT_TIMEOUT - 1);
        end
      end
      ST_WAIT: begin
        if (hdl_error || (tmr_zero && !hdl_done)) begin
          code_d    = hdl_error ? STAT_HDL_ERR : STAT_TIMEOUT;
          stale_d   = 1'b0;
          release_d = 1'b0;
          state_d   = ST_RECOVER;
          tmr_load  = 1'b1;
          tmr_val   = TIMER_W'(RECOVER_CYCLES - 1);
        end else if (hdl_done) begin
          code_d  = STAT_OK;
          state_d = ST_REPORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RECOVER: begin
        // Hold the handler in reset, then give it one released cycle before moving on.
        if (release_q) begin
          release_d = 1'b0;
          stale_d   = 1'b0;
          state_d   = stale_q ? ST_IDLE : ST_REPORT;
        end else if (tmr_zero) begin
          release_d = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      code_q     <= STAT_OK;
      stale_q    <= 1'b0;
      release_q  <= 1'b0;
      alive_q    <= 1'b0;
      rx_ready_q <= 1'b0;
      ok_q       <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      stale_q    <= stale_d;
      release_q  <= release_d;
      alive_q    <= 1'b1;
      rx_ready_q <= (state_d == ST_IDLE) || (state_d == ST_COLLECT);
      if (state_q == ST_REPORT) begin
        if (code_q == STAT_OK) ok_q <= sat_inc(ok_q);
        else                   err_q <= sat_inc(err_q);
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign buf_wr_en    = accept;
  assign buf_wr_addr  = accept ? idx_q : '0;
  assign buf_wr_data  = accept ? rx_data : 8'h00;
  assign hdl_start    = (state_q == ST_START) && !hdl_busy;
  assign hdl_rst_n    = alive_q && !((state_q == ST_RECOVER) && !release_q);
  assign status_valid = (state_q == ST_REPORT);
  assign status_code  = code_q;
  assign ok_count     = ok_q;
  assign err_count    = err_q;
  assign state_dbg    = state_q;

endmodule
